// File: rtl/activation_rr_scheduler.sv
// Round-robin front end for one shared fixed-point activation unit.
// It has a two-stage issue/result pipeline, and results are tagged with the requester id.
module activation_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int INTEGER    = 10,
  parameter int FRACTION   = 22,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_bypass,
  output logic [DATA_WIDTH-1:0]         act_in,
  output logic                          act_enable,
  input  logic [DATA_WIDTH-1:0]         act_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          busy
);

  if (INTEGER + FRACTION != DATA_WIDTH || NUM_REQ < 2) begin : g_param_check
    $error("activation_rr_scheduler: Q format must fill DATA_WIDTH and NUM_REQ must be >= 2");
  end

  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       id_a;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       cand;
  logic                  found;
  logic                  valid_a;
  logic                  a_ready;
  logic                  b_ready;
  logic                  accept;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] win_data;

  // The search starts just after the last accepted requester. This rotation gives the fairness bound.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[winner] = 1'b1;
  end

  assign b_ready   = !rsp_valid || rsp_ready;
  assign a_ready   = !valid_a || b_ready;
  assign accept    = found && a_ready;
  assign req_ready = rst_n ? (grant & {NUM_REQ{a_ready}}) : '0;
  assign busy      = valid_a | rsp_valid;
  assign win_data  = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

  // Stage A drives the shared unit. Stage B captures the unit's combinational result one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a    <= 1'b0;
      act_in     <= '0;
      act_enable <= 1'b0;
      id_a       <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      if (accept) begin
        valid_a    <= 1'b1;
        act_in     <= win_data;
        act_enable <= !req_bypass[winner];
        id_a       <= winner;
        last_grant <= winner;
      end else if (b_ready) begin
        valid_a <= 1'b0;
      end

      if (valid_a && b_ready) begin
        rsp_valid <= 1'b1;
        rsp_data  <= act_out;
        rsp_id    <= id_a;
      end else if (rsp_ready && !valid_a) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_activation_rr_scheduler.sv
// Scoreboard bench for activation_rr_scheduler.
// A piecewise-linear Q10.22 sigmoid stands in for the shared activation unit.
module tb_activation_rr_scheduler;

  localparam int DW   = 32;
  localparam int N    = 4;
  localparam int IW   = $clog2(N);
  localparam int FRAC = 22;
  localparam longint ONE = longint'(1) << FRAC;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_bypass;
  logic [DW-1:0]   act_in;
  logic            act_enable;
  logic [DW-1:0]   act_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            busy;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mdl_a, mdl_b;
  int   mdl_ptr;
  int   wait_cnt[N];
  bit   acc_hit;
  int   acc_id;

  // PLAN sigmoid approximation in Q10.22. It is used as the golden activation unit.
  function automatic logic [DW-1:0] golden_sigmoid(input logic [DW-1:0] x);
    longint sx, ax, y;
    sx = longint'($signed(x));
    ax = (sx < 0) ? -sx : sx;
    if (ax >= 5 * ONE)               y = ONE;
    else if (ax >= (19 * ONE) / 8)   y = ax / 32 + (27 * ONE) / 32;
    else if (ax >= ONE)              y = ax / 8 + (5 * ONE) / 8;
    else                             y = ax / 4 + ONE / 2;
    if (sx < 0) y = ONE - y;
    return DW'(y);
  endfunction

  assign act_out = act_enable ? golden_sigmoid(act_in) : act_in;

  always #5 clk = ~clk;

  activation_rr_scheduler #(
    .DATA_WIDTH(DW), .INTEGER(10), .FRACTION(FRAC), .NUM_REQ(N)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_bypass(req_bypass), .act_in(act_in), .act_enable(act_enable),
    .act_out(act_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic int ref_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    return -1;
  endfunction

  // Drive one cycle of inputs and check the handshake outputs against the occupancy model.
  // Any accepted request gets its expected response queued.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] byp,
                               input logic [N*DW-1:0] data, input logic rr);
    int w;
    bit b_rdy, a_rdy;
    logic [N-1:0] exp_ready;
    logic [DW-1:0] operand;
    @(negedge clk);
    req_valid  = v;
    req_bypass = byp;
    req_data   = data;
    rsp_ready  = rr;
    #4;
    w = ref_winner(v);
    b_rdy = !mdl_b || rr;
    a_rdy = !mdl_a || b_rdy;
    exp_ready = '0;
    if (w >= 0 && a_rdy) exp_ready[w] = 1'b1;
    checkOutput("req_ready", DW'(req_ready), DW'(exp_ready));
    checkOutput("rsp_valid", DW'(rsp_valid), DW'(mdl_b));
    checkOutput("busy", DW'(busy), DW'(mdl_a || mdl_b));
    acc_hit = (w >= 0) && a_rdy;
    acc_id  = w;
    if (mdl_a && b_rdy) mdl_b = 1'b1;
    else if (rr)        mdl_b = 1'b0;
    for (int i = 0; i < N; i++) if (!v[i]) wait_cnt[i] = 0;
    if (acc_hit) begin
      operand = data[w*DW +: DW];
      sb.push_back('{id: IW'(w), data: byp[w] ? operand : golden_sigmoid(operand)});
      total++;
      if (wait_cnt[w] > N - 1) begin
        bad++;
        $display("[TB] FAIL wait_bound requester=%0d waited=%0d limit=%0d", w, wait_cnt[w], N - 1);
      end
      for (int i = 0; i < N; i++) if (i != w && v[i]) wait_cnt[i]++;
      wait_cnt[w] = 0;
      mdl_ptr = w;
      mdl_a = 1'b1;
    end else if (b_rdy) begin
      mdl_a = 1'b0;
    end
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", DW'(rsp_valid), '0);
    checkOutput("rst_busy", DW'(busy), '0);
    checkOutput("rst_act_in", act_in, '0);
    checkOutput("rst_act_enable", DW'(act_enable), '0);
    checkOutput("rst_rsp_data", rsp_data, '0);
    checkOutput("rst_rsp_id", DW'(rsp_id), '0);
    checkOutput("rst_req_ready", DW'(req_ready), '0);
    repeat (cycles) @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    sb.delete();
    mdl_a = 1'b0;
    mdl_b = 1'b0;
    mdl_ptr = N - 1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Monitor: pops the scoreboard on each response handshake and checks that stalled outputs hold.
  initial begin
    rsp_t e;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [IW-1:0] prev_id = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stall_data", rsp_data, prev_data);
          checkOutput("stall_id", DW'(rsp_id), DW'(prev_id));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_rsp id=%0d data=0x%0h expected=none", rsp_id, rsp_data);
          end else begin
            e = sb.pop_front();
            checkOutput("rsp_id", DW'(rsp_id), DW'(e.id));
            checkOutput("rsp_data", rsp_data, e.data);
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
        prev_id    = rsp_id;
      end
    end
  end

  initial begin
    logic [N*DW-1:0] d;
    logic [N-1:0]    pend;
    logic [N-1:0]    pbyp;
    logic [DW-1:0]   pdata[N];
    int              guard;

    rst_n      = 1'b0;
    req_valid  = '1;
    req_bypass = '0;
    req_data   = '0;
    rsp_ready  = 1'b1;
    doReset(2);

    // Single activation request from requester 2, operand 0 -> sigmoid = 0.5.
    d = '0;
    applyStimulus(4'b0100, 4'b0000, d, 1'b1);
    applyStimulus('0, '0, d, 1'b1);
    checkOutput("single_act_enable", DW'(act_enable), DW'(1));
    checkOutput("single_act_in", act_in, '0);
    applyStimulus('0, '0, d, 1'b1);
    checkOutput("single_rsp_data", rsp_data, 32'h0020_0000);
    checkOutput("single_rsp_id", DW'(rsp_id), DW'(2));

    // Bypass from requester 1.
    d = '0;
    d[1*DW +: DW] = 32'h1234_5678;
    applyStimulus(4'b0010, 4'b0010, d, 1'b1);
    applyStimulus('0, '0, d, 1'b1);
    checkOutput("bypass_act_enable", DW'(act_enable), '0);
    checkOutput("bypass_act_in", act_in, 32'h1234_5678);
    applyStimulus('0, '0, d, 1'b1);
    checkOutput("bypass_rsp_data", rsp_data, 32'h1234_5678);
    checkOutput("bypass_rsp_id", DW'(rsp_id), DW'(1));

    // Round robin with every requester active.
    doReset(2);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < N; j++) d[j*DW +: DW] = $urandom;
      applyStimulus('1, 4'b0101, d, 1'b1);
      checkOutput("rr_order", DW'(acc_id), DW'(i % N));
    end
    repeat (3) applyStimulus('0, '0, d, 1'b1);

    // Backpressure: both stages fill, then rsp_ready stays low for 5 cycles.
    for (int j = 0; j < N; j++) d[j*DW +: DW] = $urandom;
    applyStimulus(4'b0001, '0, d, 1'b1);
    applyStimulus(4'b0010, '0, d, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0100, '0, d, 1'b0);
      checkOutput("bp_req_ready", DW'(req_ready), '0);
    end
    repeat (4) applyStimulus('0, '0, d, 1'b1);

    // Reset with both stages full; nothing may emerge afterwards.
    applyStimulus(4'b0001, '0, d, 1'b1);
    applyStimulus(4'b0010, '0, d, 1'b0);
    req_valid = 4'b0010;
    doReset(2);
    applyStimulus('1, '0, d, 1'b1);
    checkOutput("post_reset_grant", DW'(acc_id), '0);
    repeat (4) applyStimulus('0, '0, d, 1'b1);

    // Random soak. Each requester holds valid until it is accepted.
    pend = '0;
    pbyp = '0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          pdata[i] = $urandom;
          pbyp[i]  = 1'($urandom_range(0, 1));
        end
        d[i*DW +: DW] = pdata[i];
      end
      applyStimulus(pend, pbyp, d, $urandom_range(0, 3) != 0);
      if (acc_hit) pend[acc_id] = 1'b0;
    end

    guard = 0;
    while ((mdl_a || mdl_b) && guard < 20) begin
      applyStimulus('0, '0, d, 1'b1);
      guard++;
    end
    #1;
    checkOutput("drain_empty", DW'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
